// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller:
// opcodes, funct codes, datapath select values and FSM states.
package multi_cycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [1:0] NPC_PC4 = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_JAL = 2'd2;
    localparam logic [1:0] NPC_JR  = 2'd3;

    localparam logic [1:0] WR_RT  = 2'd0;
    localparam logic [1:0] WR_RD  = 2'd1;
    localparam logic [1:0] WR_R31 = 2'd2;

    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_DMRD = 2'd1;
    localparam logic [1:0] WD_PC4  = 2'd2;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_OR  = 2'd2;
    localparam logic [1:0] ALU_LUI = 2'd3;

    localparam logic [1:0] DM_WORD = 2'd0;
    localparam logic [1:0] DM_HALF = 2'd1;
    localparam logic [1:0] DM_BYTE = 2'd2;

    // One bit per decoded instruction; all-zero means illegal.
    typedef struct packed {
        logic add;
        logic sub;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic lh;
        logic lb;
        logic sw;
        logic sh;
        logic sb;
        logic beq;
        logic jal;
    } iclass_t;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and comparator in,
// select/enable lines, debug state and retire counter out.
interface multi_cycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       func;
    logic             cmp_true;
    logic             PCWrEn;
    logic             IRWrEn;
    logic [1:0]       NPCOp;
    logic             RFWrEn;
    logic [1:0]       RFWRSel;
    logic [1:0]       RFWDSel;
    logic [1:0]       ALUOp;
    logic             ALUBSel;
    logic             EXTOp;
    logic             DMWrEn;
    logic [1:0]       DMOp;
    logic             DMEXTOp;
    logic [2:0]       state;
    logic             retire;
    logic [CNT_W-1:0] retired;
    logic             illegal;

    modport master (
        input  opcode, func, cmp_true,
        output PCWrEn, IRWrEn, NPCOp, RFWrEn, RFWRSel, RFWDSel,
        output ALUOp, ALUBSel, EXTOp, DMWrEn, DMOp, DMEXTOp,
        output state, retire, retired, illegal
    );

    modport slave (
        output opcode, func, cmp_true,
        input  PCWrEn, IRWrEn, NPCOp, RFWrEn, RFWRSel, RFWDSel,
        input  ALUOp, ALUBSel, EXTOp, DMWrEn, DMOp, DMEXTOp,
        input  state, retire, retired, illegal
    );
endinterface

// File: rtl/multi_cycle_ctrl_instr_decode.sv
// Combinational opcode/func decode into a one-hot instruction
// class plus an illegal flag.
module instr_decode
    import multi_cycle_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output iclass_t    ic,
    output logic       illegal
);
    always_comb begin
        ic = '0;
        unique case (opcode)
            OP_RTYPE: begin
                unique case (func)
                    FN_ADD:  ic.add = 1'b1;
                    FN_SUB:  ic.sub = 1'b1;
                    FN_JR:   ic.jr  = 1'b1;
                    default: ;
                endcase
            end
            OP_ORI:  ic.ori = 1'b1;
            OP_LUI:  ic.lui = 1'b1;
            OP_LW:   ic.lw  = 1'b1;
            OP_LH:   ic.lh  = 1'b1;
            OP_LB:   ic.lb  = 1'b1;
            OP_SW:   ic.sw  = 1'b1;
            OP_SH:   ic.sh  = 1'b1;
            OP_SB:   ic.sb  = 1'b1;
            OP_BEQ:  ic.beq = 1'b1;
            OP_JAL:  ic.jal = 1'b1;
            default: ;
        endcase
        illegal = ~|ic;
    end
endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer
// with memory wait states and a retired-instruction counter.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 32
) (
    input logic               clk,
    input logic               reset,
    multi_cycle_ctrl_if.master bus
);
    localparam logic [3:0] WLAST = 4'(MEM_WAIT);

    state_t           state;
    logic [3:0]       wcnt;
    logic [CNT_W-1:0] retired;
    iclass_t          ic;
    logic             bad;
    logic             ld, st, rt, last;
    logic             pc_wr, ir_wr, rf_wr, dm_wr, ret;

    instr_decode u_dec (
        .opcode  (bus.opcode),
        .func    (bus.func),
        .ic      (ic),
        .illegal (bad)
    );

    assign ld   = ic.lw | ic.lh | ic.lb;
    assign st   = ic.sw | ic.sh | ic.sb;
    assign rt   = ic.add | ic.sub;
    assign last = (wcnt == WLAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            wcnt    <= '0;
            retired <= '0;
        end else begin
            if (ret) retired <= retired + CNT_W'(1);
            unique case (state)
                S_FETCH: begin
                    if (last) begin
                        state <= S_DECODE;
                        wcnt  <= '0;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                S_DECODE: begin
                    if (ic.jal | ic.jr | ic.beq) state <= S_FETCH;
                    else if (bad)                state <= S_HALT;
                    else                         state <= S_EXEC;
                end
                S_EXEC: state <= (ld | st) ? S_MEM : S_WB;
                S_MEM: begin
                    if (last) begin
                        state <= st ? S_FETCH : S_WB;
                        wcnt  <= '0;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                S_WB:    state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_wr       = 1'b0;
        ir_wr       = 1'b0;
        rf_wr       = 1'b0;
        dm_wr       = 1'b0;
        ret         = 1'b0;
        bus.NPCOp   = NPC_PC4;
        bus.RFWRSel = WR_RT;
        bus.RFWDSel = WD_ALU;
        bus.ALUOp   = ALU_ADD;
        bus.ALUBSel = 1'b0;
        bus.EXTOp   = 1'b0;
        bus.DMOp    = DM_WORD;
        bus.DMEXTOp = 1'b0;
        bus.illegal = 1'b0;
        unique case (state)
            S_FETCH: begin
                ir_wr = last;
                pc_wr = last;
            end
            S_DECODE: begin
                unique case (1'b1)
                    ic.jal: begin
                        pc_wr       = 1'b1;
                        bus.NPCOp   = NPC_JAL;
                        rf_wr       = 1'b1;
                        bus.RFWRSel = WR_R31;
                        bus.RFWDSel = WD_PC4;
                        ret         = 1'b1;
                    end
                    ic.jr: begin
                        pc_wr     = 1'b1;
                        bus.NPCOp = NPC_JR;
                        ret       = 1'b1;
                    end
                    ic.beq: begin
                        pc_wr     = bus.cmp_true;
                        bus.NPCOp = NPC_BR;
                        ret       = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EXEC: begin
                unique case (1'b1)
                    ic.sub:  bus.ALUOp = ALU_SUB;
                    ic.ori:  bus.ALUOp = ALU_OR;
                    ic.lui:  bus.ALUOp = ALU_LUI;
                    default: bus.ALUOp = ALU_ADD;
                endcase
                bus.ALUBSel = ~rt;
                bus.EXTOp   = ld | st;
            end
            S_MEM: begin
                if (ic.lh | ic.sh)      bus.DMOp = DM_HALF;
                else if (ic.lb | ic.sb) bus.DMOp = DM_BYTE;
                bus.DMEXTOp = ic.lh | ic.lb;
                dm_wr       = st & last;
                ret         = st & last;
            end
            S_WB: begin
                rf_wr       = 1'b1;
                bus.RFWRSel = rt ? WR_RD : WR_RT;
                bus.RFWDSel = ld ? WD_DMRD : WD_ALU;
                ret         = 1'b1;
            end
            S_HALT:  bus.illegal = 1'b1;
            default: ;
        endcase
    end

    // Reset overrides the FETCH-cycle enables so nothing fires mid-reset.
    assign bus.PCWrEn  = pc_wr & ~reset;
    assign bus.IRWrEn  = ir_wr & ~reset;
    assign bus.RFWrEn  = rf_wr & ~reset;
    assign bus.DMWrEn  = dm_wr & ~reset;
    assign bus.retire  = ret & ~reset;
    assign bus.state   = state;
    assign bus.retired = retired;
endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Multi-cycle control unit for the MIPS subset core: a state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It drives the same datapath select/enable signals as the single-cycle controller, adds byte and halfword loads/stores, configurable memory wait states, an illegal-instruction halt and a retired-instruction counter. It sits between the instruction register (opcode/func) and the multi-cycle datapath (PC, IR, RF, ALU, DM).

## Interface
- MEM_WAIT, 0, extra wait cycles per IM/DM access (0..15)
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- opcode  in  6  IR[31:26]
- func  in  6  IR[5:0]
- cmp_true  in  1  datapath comparator result (rs==rt), valid in DECODE
- PCWrEn  out  1  PC load enable
- IRWrEn  out  1  IR load enable
- NPCOp  out  2  PC4=0, BR=1, JAL=2, JR=3
- RFWrEn  out  1  register file write enable
- RFWRSel  out  2  rt=0, rd=1, r31=2
- RFWDSel  out  2  ALU=0, DMRD=1, PC4=2
- ALUOp  out  2  ADD=0, SUB=1, OR=2, LUI=3
- ALUBSel  out  1  rt=0, imm=1
- EXTOp  out  1  zero=0, sign=1
- DMWrEn  out  1  data memory write enable
- DMOp  out  2  word=0, half=1, byte=2
- DMEXTOp  out  1  load extension: zero=0, sign=1
- state  out  3  current FSM state (debug)
- retire  out  1  one-cycle pulse on instruction completion
- retired  out  CNT_W  count of completed instructions
- illegal  out  1  high while in HALT

## Operation
- Decoded set: add(000000/100000), sub(000000/100010), jr(000000/001000), ori 001101, lui 001111, lw 100011, lh 100001, lb 100000, sw 101011, sh 101001, sb 101000, beq 000100, jal 000011; anything else is illegal.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH: occupies 1+MEM_WAIT cycles via wait counter; on last cycle IRWrEn=1, PCWrEn=1, NPCOp=PC4; -> DECODE.
- DECODE: one cycle. jal: PCWrEn=1, NPCOp=JAL, RFWrEn=1, RFWRSel=r31, RFWDSel=PC4, retire -> FETCH. jr: PCWrEn=1, NPCOp=JR, retire -> FETCH. beq: PCWrEn=cmp_true, NPCOp=BR, retire -> FETCH. Illegal -> HALT. Else -> EXEC.
- EXEC: one cycle. ALUOp: add/loads/stores ADD, sub SUB, ori OR, lui LUI. ALUBSel=imm for ori/lui/loads/stores. EXTOp=sign for loads/stores, zero otherwise. R-type/ori/lui -> WB; loads/stores -> MEM.
- MEM: 1+MEM_WAIT cycles; DMOp/DMEXTOp held stable throughout. Stores: DMWrEn=1 on last cycle only, retire, -> FETCH. Loads -> WB. DMEXTOp=sign for lh/lb, zero otherwise.
- WB: RFWrEn=1, retire, -> FETCH. RFWRSel=rd for R-type, rt otherwise; RFWDSel=DMRD for loads, ALU otherwise.
- HALT: all enables 0, illegal=1; exit only by reset.
- retired increments on each retire pulse; wraps modulo 2^CNT_W.
- Outputs not listed for a state are 0.

## Timing
- Reset (async): state=FETCH, wait counter=0, retired=0; every enable (PCWrEn, IRWrEn, RFWrEn, DMWrEn) and retire forced 0 while reset is high; all other outputs 0.
- Enables are Moore outputs of state and wait counter; only PCWrEn in DECODE depends combinationally on cmp_true.
- Latency in cycles, with W=MEM_WAIT: jal/jr/beq 2+W; add/sub/ori/lui 4+W; store 4+2W; load 5+2W.
- Wait counter clears on every state transition; reset mid-access abandons it, with no write issued.
- opcode/func are required stable from DECODE to the end of the instruction; the FSM does not latch them.

## Structure
- Shared package/header: opcode and func constants, NPCOp/ALUOp/RFWRSel/RFWDSel/DMOp/EXTOp encodings, state encoding.
- One sub-module, instr_decode: pure combinational opcode/func to one-hot instruction class plus illegal flag. The FSM, wait counter and retire counter stay in the top.

## Test plan
- MEM_WAIT=0, add: states 0,1,2,4,0; RFWrEn=1 with RFWRSel=1, RFWDSel=0 in cycle 4; retired 0->1.
- MEM_WAIT=2, lw: 9 cycles; DMOp=0 for 3 cycles; WB RFWDSel=1, RFWRSel=0; single retire pulse.
- sb then lh (MEM_WAIT=0): sb DMWrEn high exactly one cycle with DMOp=2; lh DMOp=1, DMEXTOp=1.
- beq with cmp_true=0 then 1: PCWrEn 0 then 1 in DECODE, NPCOp=1; each takes 2 cycles; jal writes RFWRSel=2, RFWDSel=2.
- opcode 111111: DECODE->HALT; illegal=1, all enables 0 for 20 cycles; reset returns to FETCH.
- reset asserted mid-MEM of sw with MEM_WAIT=3: DMWrEn never asserted, state=0, retired=0 immediately.
